// File: rtl/id_ex_issue_stage.sv
// ID/EX issue stage: decodes the instruction into ALU controls and immediate,
// then registers them with operand data, honouring stall, flush and bubbles.
module id_ex_issue_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_in,
    input  logic              instr_valid_in,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] reg_data1,
    output logic [DATA_W-1:0] reg_data2,
    output logic [DATA_W-1:0] immidiate_value,
    output logic              ALUsrc,
    output logic [3:0]        control_signals,
    output logic [4:0]        rd_out,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              ex_valid,
    output logic              illegal_instr,
    output logic [CNT_W-1:0]  issue_count,
    output logic [CNT_W-1:0]  bubble_count
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_SUB = 4'b0010,
        ALU_ADD = 4'b0011,
        ALU_SLT = 4'b0110,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef struct packed {
        logic       legal;
        alu_op_e    alu_op;
        logic       alu_src;
        logic       has_imm;
        logic       sign_ext;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
    } dec_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    dec_t              dec;
    logic [DATA_W-1:0] imm_ext;
    logic              do_bubble;
    logic              unused_fields;

    assign opcode = instr_in[31:26];
    assign funct  = instr_in[5:0];

    // rs and shamt are resolved by the register file, not here
    assign unused_fields = ^{instr_in[25:21], instr_in[10:6]};

    always_comb begin
        dec = '0;
        unique case (opcode)
            OP_RTYPE: begin
                dec.legal     = 1'b1;
                dec.rd        = instr_in[15:11];
                dec.reg_write = 1'b1;
                unique case (funct)
                    6'b100000: dec.alu_op = ALU_ADD;
                    6'b100010: dec.alu_op = ALU_SUB;
                    6'b100100: dec.alu_op = ALU_AND;
                    6'b100101: dec.alu_op = ALU_OR;
                    6'b100111: dec.alu_op = ALU_NOR;
                    6'b101010: dec.alu_op = ALU_SLT;
                    default:   dec.legal  = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
            OP_LW, OP_SW, OP_BEQ: begin
                dec.legal    = 1'b1;
                dec.has_imm  = 1'b1;
                dec.alu_src  = (opcode != OP_BEQ);
                dec.sign_ext = (opcode != OP_ANDI) && (opcode != OP_ORI);
                dec.rd       = instr_in[20:16];
                unique case (opcode)
                    OP_SLTI: dec.alu_op = ALU_SLT;
                    OP_ANDI: dec.alu_op = ALU_AND;
                    OP_ORI:  dec.alu_op = ALU_OR;
                    OP_BEQ:  dec.alu_op = ALU_SUB;
                    default: dec.alu_op = ALU_ADD;
                endcase
                dec.reg_write = (opcode != OP_SW) && (opcode != OP_BEQ);
                dec.mem_read  = (opcode == OP_LW);
                dec.mem_write = (opcode == OP_SW);
                dec.branch    = (opcode == OP_BEQ);
            end
            default: dec = '0;
        endcase
    end

    always_comb begin
        imm_ext = '0;
        if (dec.has_imm) begin
            if (dec.sign_ext)
                imm_ext = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};
            else
                imm_ext = {{(DATA_W-16){1'b0}}, instr_in[15:0]};
        end
    end

    // A flush, an empty slot or an undecodable word all enter EX as a bubble
    assign do_bubble = flush || (!stall && (!instr_valid_in || !dec.legal));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_data1       <= '0;
            reg_data2       <= '0;
            immidiate_value <= '0;
            ALUsrc          <= 1'b0;
            control_signals <= '0;
            rd_out          <= '0;
            reg_write       <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            branch          <= 1'b0;
            ex_valid        <= 1'b0;
            illegal_instr   <= 1'b0;
            issue_count     <= '0;
            bubble_count    <= '0;
        end else if (do_bubble) begin
            reg_data1       <= '0;
            reg_data2       <= '0;
            immidiate_value <= '0;
            ALUsrc          <= 1'b0;
            control_signals <= '0;
            rd_out          <= '0;
            reg_write       <= 1'b0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            branch          <= 1'b0;
            ex_valid        <= 1'b0;
            illegal_instr   <= !flush && instr_valid_in && !dec.legal;
            bubble_count    <= bubble_count + CNT_W'(1);
        end else if (stall) begin
            illegal_instr <= 1'b0;
        end else begin
            reg_data1       <= rf_data1;
            reg_data2       <= rf_data2;
            immidiate_value <= imm_ext;
            ALUsrc          <= dec.alu_src;
            control_signals <= dec.alu_op;
            rd_out          <= dec.rd;
            reg_write       <= dec.reg_write;
            mem_read        <= dec.mem_read;
            mem_write       <= dec.mem_write;
            branch          <= dec.branch;
            ex_valid        <= 1'b1;
            illegal_instr   <= 1'b0;
            issue_count     <= issue_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Bench for id_ex_issue_stage: directed cases plus random traffic
// compared every cycle against a behavioural model.
module tb_id_ex_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr_in = '0;
    logic        instr_valid_in = 1'b0;
    logic [31:0] rf_data1 = '0;
    logic [31:0] rf_data2 = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic [31:0] reg_data1, reg_data2, immidiate_value;
    logic        ALUsrc, reg_write, mem_read, mem_write, branch;
    logic        ex_valid, illegal_instr;
    logic [3:0]  control_signals;
    logic [4:0]  rd_out;
    logic [31:0] issue_count, bubble_count;

    logic [31:0] w_d1, w_d2, w_imm;
    logic        w_src, w_rw, w_mr, w_mw, w_br, w_v, w_ill;
    logic [3:0]  w_ctl;
    logic [4:0]  w_rd;
    logic [3:0]  w_ic, w_bc;

    always #5 clk = ~clk;

    id_ex_issue_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in),
        .instr_valid_in(instr_valid_in),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .stall(stall), .flush(flush),
        .reg_data1(reg_data1), .reg_data2(reg_data2),
        .immidiate_value(immidiate_value), .ALUsrc(ALUsrc),
        .control_signals(control_signals), .rd_out(rd_out),
        .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch),
        .ex_valid(ex_valid), .illegal_instr(illegal_instr),
        .issue_count(issue_count), .bubble_count(bubble_count)
    );

    // narrow-counter copy so wrap-around is reachable in a short run
    id_ex_issue_stage #(.DATA_W(32), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .instr_in(instr_in),
        .instr_valid_in(instr_valid_in),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .stall(stall), .flush(flush),
        .reg_data1(w_d1), .reg_data2(w_d2),
        .immidiate_value(w_imm), .ALUsrc(w_src),
        .control_signals(w_ctl), .rd_out(w_rd),
        .reg_write(w_rw), .mem_read(w_mr),
        .mem_write(w_mw), .branch(w_br),
        .ex_valid(w_v), .illegal_instr(w_ill),
        .issue_count(w_ic), .bubble_count(w_bc)
    );

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        src;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        v;
        logic        ill;
        logic [31:0] ic;
        logic [31:0] bc;
    } exp_t;

    exp_t m;
    int   total = 0;
    int   passed = 0;
    bit   chk_en = 1'b0;

    logic [5:0] opcs [7] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
    logic [5:0] functs [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        else
            passed++;
    endtask

    function automatic void spec_decode(
        input  logic [31:0] ins,
        output logic        ok,
        output logic [3:0]  op,
        output logic        src,
        output logic [31:0] imm,
        output logic [4:0]  rd,
        output logic        rw, mr, mw, br);
        logic [31:0] sx;
        logic [31:0] zx;
        sx  = {{16{ins[15]}}, ins[15:0]};
        zx  = {16'h0000, ins[15:0]};
        ok  = 1'b1;
        op  = 4'h0;
        src = 1'b1;
        imm = sx;
        rd  = ins[20:16];
        rw  = 1'b0;
        mr  = 1'b0;
        mw  = 1'b0;
        br  = 1'b0;
        case (ins[31:26])
            6'h00: begin
                src = 1'b0;
                imm = 32'h0;
                rd  = ins[15:11];
                rw  = 1'b1;
                case (ins[5:0])
                    6'h20:   op = 4'b0011;
                    6'h22:   op = 4'b0010;
                    6'h24:   op = 4'b0000;
                    6'h25:   op = 4'b0001;
                    6'h27:   op = 4'b1100;
                    6'h2A:   op = 4'b0110;
                    default: ok = 1'b0;
                endcase
            end
            6'h08: begin op = 4'b0011; rw = 1'b1; end
            6'h0A: begin op = 4'b0110; rw = 1'b1; end
            6'h0C: begin op = 4'b0000; rw = 1'b1; imm = zx; end
            6'h0D: begin op = 4'b0001; rw = 1'b1; imm = zx; end
            6'h23: begin op = 4'b0011; rw = 1'b1; mr = 1'b1; end
            6'h2B: begin op = 4'b0011; mw = 1'b1; end
            6'h04: begin op = 4'b0010; src = 1'b0; br = 1'b1; end
            default: ok = 1'b0;
        endcase
    endfunction

    function automatic exp_t bubble_of(input exp_t cur);
        exp_t n;
        n    = '0;
        n.ic = cur.ic;
        n.bc = cur.bc + 32'd1;
        return n;
    endfunction

    function automatic exp_t model_step(
        input exp_t cur, input logic [31:0] ins, input logic v,
        input logic [31:0] a, input logic [31:0] b,
        input logic st, input logic fl);
        exp_t n;
        logic ok;
        n     = cur;
        n.ill = 1'b0;
        spec_decode(ins, ok, n.ctl, n.src, n.imm, n.rd,
                    n.rw, n.mr, n.mw, n.br);
        if (fl) begin
            n = bubble_of(cur);
        end else if (st) begin
            n     = cur;
            n.ill = 1'b0;
        end else if (!v) begin
            n = bubble_of(cur);
        end else if (!ok) begin
            n     = bubble_of(cur);
            n.ill = 1'b1;
        end else begin
            n.d1 = a;
            n.d2 = b;
            n.v  = 1'b1;
            n.ic = cur.ic + 32'd1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)
            m <= '0;
        else
            m <= model_step(m, instr_in, instr_valid_in,
                            rf_data1, rf_data2, stall, flush);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("reg_data1", reg_data1, m.d1);
            check("reg_data2", reg_data2, m.d2);
            check("imm", immidiate_value, m.imm);
            check("ALUsrc", ALUsrc, m.src);
            check("ctl", control_signals, m.ctl);
            check("rd_out", rd_out, m.rd);
            check("reg_write", reg_write, m.rw);
            check("mem_read", mem_read, m.mr);
            check("mem_write", mem_write, m.mw);
            check("branch", branch, m.br);
            check("ex_valid", ex_valid, m.v);
            check("illegal", illegal_instr, m.ill);
            check("issue_count", issue_count, m.ic);
            check("bubble_count", bubble_count, m.bc);
            check("w_issue", w_ic, m.ic[3:0]);
            check("w_bubble", w_bc, m.bc[3:0]);
        end
    end

    task automatic cyc(input logic [31:0] ins, input logic v,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic fl);
        instr_in       = ins;
        instr_valid_in = v;
        rf_data1       = a;
        rf_data2       = b;
        stall          = st;
        flush          = fl;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k == 0) begin
            r[31:26] = 6'h00;
            r[5:0]   = functs[$urandom_range(0, 5)];
        end else if (k <= 7) begin
            r[31:26] = opcs[k-1];
        end else if (k == 8) begin
            r[31:26] = 6'h00;
        end
        return r;
    endfunction

    task automatic async_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst ex_valid", ex_valid, 1'b0);
        check("arst issue", issue_count, 32'h0);
        check("arst bubble", bubble_count, 32'h0);
        check("arst ctl", control_signals, 4'h0);
        check("arst data1", reg_data1, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst ex_valid", ex_valid, 1'b0);
        check("rst issue", issue_count, 32'h0);
        check("rst bubble", bubble_count, 32'h0);
        check("rst imm", immidiate_value, 32'h0);
        chk_en = 1'b1;
        rst    = 1'b0;

        cyc(32'h00221820, 1'b1, 32'd5, 32'd7, 1'b0, 1'b0);
        check("add ctl", control_signals, 4'b0011);
        check("add src", ALUsrc, 1'b0);
        check("add rd", rd_out, 5'd3);
        check("add d1", reg_data1, 32'd5);
        check("add d2", reg_data2, 32'd7);
        check("add rw", reg_write, 1'b1);
        check("add v", ex_valid, 1'b1);

        cyc(32'h2024FFFF, 1'b1, 32'd5, 32'd7, 1'b0, 1'b0);
        check("addi src", ALUsrc, 1'b1);
        check("addi imm", immidiate_value, 32'hFFFFFFFF);
        check("addi rd", rd_out, 5'd4);
        check("addi ic", issue_count, 32'd2);

        cyc(32'h3425FFFF, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
        check("ori imm", immidiate_value, 32'h0000FFFF);
        check("ori ctl", control_signals, 4'b0001);

        cyc(32'h28228000, 1'b1, 32'd1, 32'd2, 1'b0, 1'b0);
        check("slti imm", immidiate_value, 32'hFFFF8000);
        check("slti ctl", control_signals, 4'b0110);

        cyc(32'hAC220004, 1'b1, 32'd9, 32'd10, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(rand_instr(), 1'b1, $urandom, $urandom, 1'b1, 1'b0);
            check("stall mw", mem_write, 1'b1);
            check("stall d2", reg_data2, 32'd10);
            check("stall ic", issue_count, 32'd5);
        end
        cyc(rand_instr(), 1'b1, $urandom, $urandom, 1'b1, 1'b1);
        check("flush v", ex_valid, 1'b0);
        check("flush mw", mem_write, 1'b0);
        check("flush bc", bubble_count, 32'd1);

        cyc(32'hFC000000, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
        check("ill v", ex_valid, 1'b0);
        check("ill rw", reg_write, 1'b0);
        check("ill pulse", illegal_instr, 1'b1);
        check("ill bc", bubble_count, 32'd2);
        check("ill ic", issue_count, 32'd5);
        cyc(32'h00221820, 1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
        check("ill clear", illegal_instr, 1'b0);

        cyc(32'h10220003, 1'b1, 32'd8, 32'd8, 1'b0, 1'b0);
        check("beq ctl", control_signals, 4'b0010);
        check("beq br", branch, 1'b1);
        check("beq src", ALUsrc, 1'b0);
        check("beq imm", immidiate_value, 32'd3);
        for (int i = 0; i < 9; i++)
            cyc(32'h20210001, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        check("wrap narrow", w_ic, 4'h0);
        check("wrap wide", issue_count, 32'd16);

        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350)
                async_reset();
            cyc(rand_instr(), $urandom_range(0, 9) != 0,
                $urandom, $urandom,
                $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_issue_stage.md
Name: id_ex_issue_stage

Overview:
- ID/EX pipeline stage on the producer side of the ALU operand/control interface.
- Decodes the instruction word into the 4-bit ALU operation code, ALUsrc and the immediate value, then registers these with the operand data.
- Supports pipeline stall (hold) and flush (bubble), flags undecodable instructions, and keeps issue and bubble counters for the hazard unit and debug.

Parameters:
- DATA_W, 32, operand/immediate width.
- CNT_W, 32, width of the issue_count and bubble_count counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- instr_in  in  32  instruction word from IF/ID.
- instr_valid_in  in  1  instr_in holds a real instruction.
- rf_data1  in  DATA_W  register file read data for rs.
- rf_data2  in  DATA_W  register file read data for rt.
- stall  in  1  hold every stage register and counter.
- flush  in  1  load a bubble.
- reg_data1  out  DATA_W  ALU operand A.
- reg_data2  out  DATA_W  ALU operand B / store data.
- immidiate_value  out  DATA_W  extended immediate.
- ALUsrc  out  1  1 = ALU uses the immediate.
- control_signals  out  4  ALU operation code.
- rd_out  out  5  destination register.
- reg_write  out  1  write-back enable.
- mem_read  out  1  load.
- mem_write  out  1  store.
- branch  out  1  beq.
- ex_valid  out  1  EX stage holds a valid instruction.
- illegal_instr  out  1  one-cycle pulse on an undecodable instruction.
- issue_count  out  CNT_W  count of valid instructions issued.
- bubble_count  out  CNT_W  count of bubbles loaded.

Behaviour:
- Reset:
  - One clock (clk); reset rst is asynchronous and active-high.
  - While rst=1, every output is 0, including both counters.
- ALU operation codes: 0000 AND, 0001 OR, 0010 SUB, 0011 ADD, 0110 SLT, 1100 NOR.
- R-type decode (opcode 000000), selected by funct:
  - Funct map: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
  - ALUsrc=0, rd_out=instr[15:11], reg_write=1.
  - Any other funct is illegal.
- I-type decode:
  - addi 001000: ADD, sign-extend, reg_write=1.
  - slti 001010: SLT, sign-extend, reg_write=1.
  - andi 001100: AND, zero-extend, reg_write=1.
  - ori 001101: OR, zero-extend, reg_write=1.
  - lw 100011: ADD, sign-extend, mem_read=1, reg_write=1.
  - sw 101011: ADD, sign-extend, mem_write=1.
  - beq 000100: SUB, ALUsrc=0, sign-extend, branch=1.
  - Common to all I-types: rd_out=instr[20:16]; ALUsrc=1 except beq; immediate from instr[15:0].
  - Any other opcode is illegal.
- Per-edge priority: rst > flush > stall > load.
- Flush:
  - ex_valid=0; all control outputs and rd_out, operands and immediate load 0.
  - bubble_count+1; illegal_instr=0.
  - Flush wins over a simultaneous stall.
- Stall (flush=0):
  - All outputs and counters hold.
  - illegal_instr clears to 0.
- Load, valid and legal instruction:
  - Decoded values and rf_data1/rf_data2 are registered; ex_valid=1.
  - issue_count+1.
- Load, instr_valid_in=0:
  - Bubble as for flush; bubble_count+1.
- Load, valid but illegal instruction:
  - Bubble; bubble_count+1; illegal_instr=1 for that cycle only.
- Latency: decode to outputs is exactly 1 clock.
- Outputs are registered only; no combinational path from inputs to outputs.
- Counters wrap: all-ones + 1 = 0, with no saturation and no flag.
- Reset mid-stall or mid-flush: outputs go to 0 immediately; normal loading resumes on the first edge after rst falls.

Test Plan:
- Reset: assert rst mid-operation -> all outputs 0 asynchronously, before the next edge; counters 0.
- Load sequence:
  - Stimulus: add $3,$1,$2 (0x00221820) with rf_data1=5, rf_data2=7, then addi $4,$1,-1 (0x2024FFFF).
  - Edge 1 -> control_signals=0011, ALUsrc=0, rd_out=3, reg_data1=5, reg_data2=7, reg_write=1, ex_valid=1.
  - Edge 2 -> ALUsrc=1, immidiate_value=0xFFFFFFFF, rd_out=4.
  - issue_count=2.
- Extension check: ori 0x3425FFFF -> immidiate_value=0x0000FFFF, control_signals=0001. Then slti imm 0x8000 -> immidiate_value=0xFFFF8000, control_signals=0110.
- Stall/flush:
  - Load sw; then stall=1 for 3 cycles with changing inputs -> outputs and counters unchanged, mem_write=1 held.
  - Then stall=1 and flush=1 together -> ex_valid=0, mem_write=0, bubble_count+1.
- Illegal instruction: opcode 111111 with valid=1 -> ex_valid=0, reg_write=0, illegal_instr=1 for exactly 1 cycle, bubble_count+1, issue_count unchanged.
- Wrap: force issue_count to 0xFFFFFFFF via a long run or a sim deposit; issue one instruction -> issue_count=0; beq -> control_signals=0010, branch=1, ALUsrc=0.
